// File: rtl/fir_hit_window.sv
// Baseline-tracking hit detector emitting framed windows of baseline-subtracted samples.
// Optional macro HIT_BIPOLAR_EN: negative excursions below -THRESHOLD also trigger.
module fir_hit_window #(
    parameter int PRE      = 4,
    parameter int POST     = 12,
    parameter int BL_SHIFT = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [11:0]        DATA_IN,
    input  logic [11:0]        THRESHOLD,
    output logic signed [12:0] DOUT,
    output logic               DOUT_VALID,
    output logic               DOUT_FIRST,
    output logic               DOUT_LAST,
    output logic [11:0]        BASELINE,
    output logic [15:0]        HIT_COUNT
);

    localparam int ACC_W = 12 + BL_SHIFT;
    localparam int DEPTH = PRE + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int WIN   = PRE + POST;
    localparam int CW    = $clog2(WIN + 1);

    typedef enum logic [1:0] {
        ST_WARM,
        ST_IDLE,
        ST_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [15:0]         hits_q, hits_d;
    logic signed [12:0]  dout_q, dout_d;
    logic                valid_q, valid_d;
    logic                first_q, first_d;
    logic                last_q, last_d;

    logic signed [12:0]  dl_q [DEPTH];
    logic signed [12:0]  dl_rd;
    logic signed [12:0]  wr_data;
    logic [DEPTH-1:0]    dl_we;

    logic signed [12:0]  diff;
    logic signed [12:0]  thr_s;
    logic [ACC_W-1:0]    acc_upd;
    logic                hit;

    assign BASELINE = acc_q[ACC_W-1:BL_SHIFT];
    assign diff     = $signed({1'b0, DATA_IN} - {1'b0, BASELINE});
    assign thr_s    = $signed({1'b0, THRESHOLD});

`ifdef HIT_BIPOLAR_EN
    logic signed [12:0] neg_thr;
    assign neg_thr = -thr_s;
    assign hit     = (diff > thr_s) || (diff < neg_thr);
`else
    assign hit     = (diff > thr_s);
`endif

    // Intermediate wrap is harmless: acc never drops below BASELINE << BL_SHIFT.
    assign acc_upd = acc_q + {{BL_SHIFT{1'b0}}, DATA_IN} - {{BL_SHIFT{1'b0}}, BASELINE};

    assign wr_data = (state_q == ST_WARM) ? 13'sd0 : diff;
    assign ptr_d   = (ptr_q == PW'(PRE)) ? '0 : ptr_q + 1'b1;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign dl_we[gi] = (ptr_q == PW'(gi));
        end
    endgenerate

    // The slot about to be overwritten holds the diff from DEPTH edges ago.
    always_comb begin
        dl_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (dl_we[i]) dl_rd = dl_q[i];
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (RST)           dl_q[i] <= '0;
            else if (dl_we[i]) dl_q[i] <= wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hits_d  = hits_q;
        dout_d  = '0;
        valid_d = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
        case (state_q)
            ST_WARM: begin
                acc_d   = {DATA_IN, {BL_SHIFT{1'b0}}};
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (hit) begin
                    state_d = ST_OUT;
                    cnt_d   = CW'(WIN);
                    if (hits_q != 16'hFFFF) hits_d = hits_q + 16'd1;
                end else begin
                    acc_d = acc_upd;
                end
            end
            ST_OUT: begin
                valid_d = 1'b1;
                dout_d  = dl_rd;
                first_d = (cnt_q == CW'(WIN));
                last_d  = (cnt_q == '0);
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_WARM;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_WARM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            hits_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            hits_q  <= hits_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign DOUT       = dout_q;
    assign DOUT_VALID = valid_q;
    assign DOUT_FIRST = first_q;
    assign DOUT_LAST  = last_q;
    assign HIT_COUNT  = hits_q;

endmodule
